// File: rtl/ctrl_unit_if.sv
// Decode bus between the instruction fields and the RV32I control unit.
// master: instruction/ALU-flag source; slave: the control unit driving datapath controls.
// Inputs op/funct3/funct7/zero; outputs pcSrc, ResultSrc, MemWrite, ALUSrc, Immsrc,
// RegWrite, ALUControl, illegal, illegal_seen.
interface ctrl_unit_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       zero;
  logic       pcSrc;
  logic [1:0] ResultSrc;
  logic       MemWrite;
  logic       ALUSrc;
  logic [1:0] Immsrc;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic       illegal;
  logic       illegal_seen;

  modport master (
    output op, funct3, funct7, zero,
    input  pcSrc, ResultSrc, MemWrite, ALUSrc, Immsrc, RegWrite, ALUControl,
           illegal, illegal_seen
  );

  modport slave (
    input  op, funct3, funct7, zero,
    output pcSrc, ResultSrc, MemWrite, ALUSrc, Immsrc, RegWrite, ALUControl,
           illegal, illegal_seen
  );
endinterface

// File: rtl/ctrl_unit.sv
// Control unit of a single-cycle RV32I core: main decoder + ALU decoder, plus sticky illegal flag.
// Latency: decode is combinational (0 cycles); illegal_seen updates on the next clk edge.
// No backpressure. Ports: clk, rst (sync, active-high, clears illegal_seen only), bus (ctrl_unit_if.slave).
// Optional feature macro CTRL_BNE_EN: when defined, op 1100011 with funct3=001 branches on ~zero.
module ctrl_unit (
  input  logic        clk,
  input  logic        rst,
  ctrl_unit_if.slave  bus
);

  logic       reg_write;
  logic [1:0] imm_src;
  logic       alu_src;
  logic       mem_write;
  logic [1:0] result_src;
  logic       branch;
  logic [1:0] alu_op;
  logic       jump;
  logic       illegal;
  logic [2:0] alu_ctrl;
  logic       branch_taken;
  logic       illegal_seen_q;
  logic       illegal_seen_d;

  // Main decoder. Unsupported opcodes fall through to the all-zero default,
  // so they never write the register file or memory.
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    illegal    = 1'b0;
    case (bus.op)
      7'b0000011: begin // lw
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      7'b0100011: begin // sw
        imm_src   = 2'b01;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      7'b0110011: begin // R-type ALU
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      7'b1100011: begin // beq (and bne when enabled)
        imm_src = 2'b10;
        branch  = 1'b1;
        alu_op  = 2'b01;
      end
      7'b0010011: begin // I-type ALU
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
      end
      7'b1101111: begin // jal
        reg_write  = 1'b1;
        imm_src    = 2'b11;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // ALU decoder. Subtract on funct3=000 needs op[5] so that addi (op[5]=0)
  // always adds even when its immediate has bit 30 set.
  always_comb begin
    alu_ctrl = 3'b000;
    case (alu_op)
      2'b01: alu_ctrl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_ctrl = (bus.op[5] & bus.funct7) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
      default: alu_ctrl = 3'b000;
    endcase
  end

`ifdef CTRL_BNE_EN
  // bne reuses the beq subtract; only the sense of the zero flag flips.
  always_comb begin
    branch_taken = branch & bus.zero;
    if (bus.funct3 == 3'b001) begin
      branch_taken = branch & ~bus.zero;
    end
  end
`else
  assign branch_taken = branch & bus.zero;
`endif

  assign illegal_seen_d = illegal_seen_q | illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign bus.pcSrc        = branch_taken | jump;
  assign bus.ResultSrc    = result_src;
  assign bus.MemWrite     = mem_write;
  assign bus.ALUSrc       = alu_src;
  assign bus.Immsrc       = imm_src;
  assign bus.RegWrite     = reg_write;
  assign bus.ALUControl   = alu_ctrl;
  assign bus.illegal      = illegal;
  assign bus.illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: scoreboard queues hold expected decode vectors
// and expected sticky-flag values; entries are pushed when stimulus is driven and
// popped when the DUT output is sampled.
module tb_ctrl_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_unit_if bus ();

  ctrl_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       reg_write;
    logic [1:0] imm_src;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic       pc_src;
    logic [2:0] alu_ctrl;
    logic       illegal;
  } exp_t;

`ifdef CTRL_BNE_EN
  localparam logic BNE_Z1 = 1'b0;
  localparam logic BNE_Z0 = 1'b1;
`else
  localparam logic BNE_Z1 = 1'b1;
  localparam logic BNE_Z0 = 1'b0;
`endif

  exp_t exp_q[$];
  logic seen_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t sample();
    sample = {bus.RegWrite, bus.Immsrc, bus.ALUSrc, bus.MemWrite, bus.ResultSrc,
              bus.pcSrc, bus.ALUControl, bus.illegal};
  endfunction

  // Stimulus word: {op[6:0], funct3[2:0], funct7, zero}
  task automatic apply(input logic [11:0] stim, input exp_t e);
    @(negedge clk);
    bus.op     = stim[11:5];
    bus.funct3 = stim[4:2];
    bus.funct7 = stim[1];
    bus.zero   = stim[0];
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e, got;
    logic s;
    rst = 1'b1;
    apply({7'b0000011, 3'b010, 1'b0, 1'b0}, 12'b1_00_1_0_01_0_000_0);
    seen_q.push_back(1'b0);
    @(posedge clk); #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL reset_decode: got %b expected %b", got, e);
    end
    s = seen_q.pop_front(); n_checks++;
    if (bus.illegal_seen !== s) begin
      n_fail++; $display("FAIL reset_seen: got %b expected %b", bus.illegal_seen, s);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_store();
    logic [23:0] vec [3];
    exp_t e, got;
    vec = '{{7'b0000011, 3'b010, 1'b0, 1'b0, 12'b1_00_1_0_01_0_000_0},
            {7'b0000011, 3'b010, 1'b1, 1'b1, 12'b1_00_1_0_01_0_000_0},
            {7'b0100011, 3'b010, 1'b0, 1'b1, 12'b0_01_1_1_00_0_000_0}};
    foreach (vec[i]) begin
      apply(vec[i][23:12], vec[i][11:0]);
      #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL load_store[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_jal();
    logic [23:0] vec [2];
    exp_t e, got;
    vec = '{{7'b1101111, 3'b000, 1'b0, 1'b0, 12'b1_11_0_0_10_1_000_0},
            {7'b1101111, 3'b101, 1'b1, 1'b1, 12'b1_11_0_0_10_1_000_0}};
    foreach (vec[i]) begin
      apply(vec[i][23:12], vec[i][11:0]);
      #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL jal[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [23:0] vec [4];
    exp_t e, got;
    vec = '{{7'b1100011, 3'b000, 1'b0, 1'b1, 12'b0_10_0_0_00_1_001_0},
            {7'b1100011, 3'b000, 1'b0, 1'b0, 12'b0_10_0_0_00_0_001_0},
            {7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, BNE_Z1, 3'b001, 1'b0},
            {7'b1100011, 3'b001, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, BNE_Z0, 3'b001, 1'b0}};
    foreach (vec[i]) begin
      apply(vec[i][23:12], vec[i][11:0]);
      #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL branch[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_alu_decode();
    logic [23:0] vec [9];
    exp_t e, got;
    vec = '{{7'b0110011, 3'b000, 1'b1, 1'b0, 12'b1_00_0_0_00_0_001_0},  // sub
            {7'b0110011, 3'b000, 1'b0, 1'b1, 12'b1_00_0_0_00_0_000_0},  // add
            {7'b0110011, 3'b111, 1'b0, 1'b0, 12'b1_00_0_0_00_0_010_0},  // and
            {7'b0110011, 3'b110, 1'b0, 1'b0, 12'b1_00_0_0_00_0_011_0},  // or
            {7'b0110011, 3'b010, 1'b0, 1'b0, 12'b1_00_0_0_00_0_101_0},  // slt
            {7'b0110011, 3'b001, 1'b1, 1'b0, 12'b1_00_0_0_00_0_000_0},  // other funct3
            {7'b0010011, 3'b000, 1'b1, 1'b0, 12'b1_00_1_0_00_0_000_0},  // addi, bit30 set
            {7'b0010011, 3'b010, 1'b0, 1'b0, 12'b1_00_1_0_00_0_101_0},  // slti
            {7'b0010011, 3'b111, 1'b1, 1'b1, 12'b1_00_1_0_00_0_010_0}}; // andi
    foreach (vec[i]) begin
      apply(vec[i][23:12], vec[i][11:0]);
      #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL alu_decode[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e, got;
    logic s;
    // Illegal opcode: decode is combinational, flag still clear before the edge.
    apply({7'b1111111, 3'b000, 1'b0, 1'b1}, 12'b0_00_0_0_00_0_000_1);
    #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL illegal_decode: got %b expected %b", got, e);
    end
    seen_q.push_back(1'b0);
    s = seen_q.pop_front(); n_checks++;
    if (bus.illegal_seen !== s) begin
      n_fail++; $display("FAIL seen_before_edge: got %b expected %b", bus.illegal_seen, s);
    end
    seen_q.push_back(1'b1);
    @(posedge clk); #1;
    s = seen_q.pop_front(); n_checks++;
    if (bus.illegal_seen !== s) begin
      n_fail++; $display("FAIL seen_set: got %b expected %b", bus.illegal_seen, s);
    end
    // Legal op afterwards: flag stays set.
    apply({7'b0110011, 3'b000, 1'b0, 1'b0}, 12'b1_00_0_0_00_0_000_0);
    seen_q.push_back(1'b1);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    s = seen_q.pop_front(); n_checks++;
    if (bus.illegal_seen !== s) begin
      n_fail++; $display("FAIL seen_sticky: got %b expected %b", bus.illegal_seen, s);
    end
    // Reset together with another illegal opcode: reset wins.
    apply({7'b0000000, 3'b000, 1'b0, 1'b0}, 12'b0_00_0_0_00_0_000_1);
    rst = 1'b1;
    #1;
    got = sample(); e = exp_q.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL illegal_zero_op: got %b expected %b", got, e);
    end
    seen_q.push_back(1'b0);
    @(posedge clk); #1;
    s = seen_q.pop_front(); n_checks++;
    if (bus.illegal_seen !== s) begin
      n_fail++; $display("FAIL seen_rst_wins: got %b expected %b", bus.illegal_seen, s);
    end
    rst = 1'b0;
    apply({7'b0000011, 3'b010, 1'b0, 1'b0}, 12'b1_00_1_0_01_0_000_0);
    seen_q.push_back(1'b0);
    @(posedge clk); #1;
    void'(exp_q.pop_front());
    s = seen_q.pop_front(); n_checks++;
    if (bus.illegal_seen !== s) begin
      n_fail++; $display("FAIL seen_stays_clear: got %b expected %b", bus.illegal_seen, s);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] vec [6];
    exp_t e, got;
    vec = '{{7'b0100011, 3'b010, 1'b0, 1'b0, 12'b0_01_1_1_00_0_000_0},
            {7'b1100011, 3'b000, 1'b0, 1'b1, 12'b0_10_0_0_00_1_001_0},
            {7'b0110011, 3'b000, 1'b1, 1'b1, 12'b1_00_0_0_00_0_001_0},
            {7'b1101111, 3'b000, 1'b0, 1'b1, 12'b1_11_0_0_10_1_000_0},
            {7'b0110111, 3'b000, 1'b0, 1'b1, 12'b0_00_0_0_00_0_000_1},
            {7'b0000011, 3'b010, 1'b0, 1'b1, 12'b1_00_1_0_01_0_000_0}};
    foreach (vec[i]) begin
      apply(vec[i][23:12], vec[i][11:0]);
      #1;
      got = sample(); e = exp_q.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL back_to_back[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.op     = 7'b0;
    bus.funct3 = 3'b0;
    bus.funct7 = 1'b0;
    bus.zero   = 1'b0;
    test_reset();
    test_load_store();
    test_jal();
    test_branch();
    test_alu_decode();
    test_illegal();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0 || seen_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d leftover entries, expected 0/0",
               exp_q.size(), seen_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
